// File: rtl/rr_grant_sequencer_if.sv
// Request/grant bundle between the requesters and the round-robin grant sequencer.
// The sequencer's grant_idx/grant_valid feed the index/enable of a 3-to-8 decoder.
interface rr_grant_sequencer_if;
  logic       arb_en;
  logic [7:0] req;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  // Requester side: drives enable and requests, observes the grant.
  modport master (
    output arb_en,
    output req,
    input  grant_idx,
    input  grant_valid,
    input  timeout
  );

  // Arbiter side.
  modport slave (
    input  arb_en,
    input  req,
    output grant_idx,
    output grant_valid,
    output timeout
  );
endinterface

// File: rtl/rr_grant_sequencer.sv
// Round-robin arbiter for 8 requesters with a bounded hold time per grant.
// Produces a registered grant index/valid pair and a one-cycle timeout pulse
// whenever a grant is revoked because it reached HOLD_MAX cycles.
module rr_grant_sequencer #(
  parameter int unsigned HOLD_MAX = 8,
  parameter int unsigned CNT_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_grant_sequencer_if.slave  bus
);

  localparam logic [CNT_W-1:0] HoldMax = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e           state_q, state_d;
  logic [2:0]       last_ptr_q, last_ptr_d;
  logic [2:0]       grant_idx_q, grant_idx_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             timeout_q, timeout_d;

  logic [7:0]       holder_mask;
  logic [7:0]       req_others;
  logic             holder_req;
  logic             win_start_found;
  logic [2:0]       win_start_idx;
  logic             win_rot_found;
  logic [2:0]       win_rot_idx;

  // Returns {found, index} of the first set bit of cand, scanning upward from
  // last+1 with wrap-around. Iterating from the lowest priority position down
  // lets the last assignment (highest priority) win.
  function automatic logic [3:0] rr_pick(input logic [7:0] cand, input logic [2:0] last);
    logic [3:0] res;
    logic [2:0] pos;
    res = 4'b0000;
    for (int i = 7; i >= 0; i--) begin
      pos = last + 3'(i + 1);
      if (cand[pos]) begin
        res = {1'b1, pos};
      end
    end
    return res;
  endfunction

  // Candidate winners: fresh search from last_ptr (idle) and a rotation
  // that excludes the current holder (release or limit handover).
  always_comb begin
    holder_mask = 8'b0000_0001 << grant_idx_q;
    req_others  = bus.req & ~holder_mask;
    holder_req  = bus.req[grant_idx_q];
    {win_start_found, win_start_idx} = rr_pick(bus.req, last_ptr_q);
    {win_rot_found, win_rot_idx}     = rr_pick(req_others, grant_idx_q);
  end

  // Next-state logic: disable beats release, release beats the hold limit.
  always_comb begin
    state_d     = state_q;
    last_ptr_d  = last_ptr_q;
    grant_idx_d = grant_idx_q;
    hold_cnt_d  = hold_cnt_q;
    timeout_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.arb_en && win_start_found) begin
          state_d     = StGrant;
          grant_idx_d = win_start_idx;
          hold_cnt_d  = CntOne;
        end
      end

      StGrant: begin
        if (!bus.arb_en) begin
          // Abandon the grant without advancing the rotation pointer.
          state_d    = StIdle;
          hold_cnt_d = '0;
        end else if (!holder_req) begin
          // Holder released: hand over on the same edge, no bubble.
          last_ptr_d = grant_idx_q;
          if (win_rot_found) begin
            grant_idx_d = win_rot_idx;
            hold_cnt_d  = CntOne;
          end else begin
            state_d    = StIdle;
            hold_cnt_d = '0;
          end
        end else if (hold_cnt_q == HoldMax) begin
          // Hold limit reached: revoke, and re-grant the holder only if it is
          // the sole requester.
          timeout_d  = 1'b1;
          last_ptr_d = grant_idx_q;
          hold_cnt_d = CntOne;
          if (win_rot_found) begin
            grant_idx_d = win_rot_idx;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + CntOne;
        end
      end

      default: begin
        state_d    = StIdle;
        hold_cnt_d = '0;
      end
    endcase
  end

  // State and output registers; reset clears any grant in flight immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      last_ptr_q  <= 3'd7;
      grant_idx_q <= 3'd0;
      hold_cnt_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_ptr_q  <= last_ptr_d;
      grant_idx_q <= grant_idx_d;
      hold_cnt_q  <= hold_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  // grant_valid comes straight from the state flop, so it is glitch-free.
  assign bus.grant_idx   = grant_idx_q;
  assign bus.grant_valid = (state_q == StGrant);
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_rr_grant_sequencer.sv
// Bench for rr_grant_sequencer: three instances (HOLD_MAX 8, 4, 1) share one
// stimulus stream; a behavioural model pushes expected outputs per edge.
module tb_rr_grant_sequencer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_grant_sequencer_if if8 ();
  rr_grant_sequencer_if if4 ();
  rr_grant_sequencer_if if1 ();

  rr_grant_sequencer #(.HOLD_MAX(8), .CNT_W(4)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  rr_grant_sequencer #(.HOLD_MAX(4), .CNT_W(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  rr_grant_sequencer #(.HOLD_MAX(1), .CNT_W(4)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  int n_pass  = 0;
  int n_total = 0;
  int n_step  = 0;

  logic [4:0] exp_q[$];  // {timeout, valid, idx}
  int         hm[3]     = '{8, 4, 1};
  string      nm[3]     = '{"h8", "h4", "h1"};
  int         m_last[3];
  int         m_cnt[3];
  int         m_idx[3];
  logic       m_busy[3];
  logic       m_to[3];

  // {timeout, grant_valid, grant_idx} of instance k.
  function automatic logic [4:0] obs(input int k);
    case (k)
      0:       return {if8.timeout, if8.grant_valid, if8.grant_idx};
      1:       return {if4.timeout, if4.grant_valid, if4.grant_idx};
      default: return {if1.timeout, if1.grant_valid, if1.grant_idx};
    endcase
  endfunction

  function automatic logic [7:0] decoded(input logic [4:0] o);
    logic [7:0] one;
    one = 8'h01;
    return o[3] ? (one << o[2:0]) : 8'h00;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    assert (got === want) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, want);
  endtask

  function automatic int pick(input logic [7:0] r, input int last);
    for (int i = 1; i <= 8; i++) begin
      if (r[(last + i) % 8]) return (last + i) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_last[k] = 7; m_cnt[k] = 0; m_idx[k] = 0; m_busy[k] = 1'b0; m_to[k] = 1'b0;
    end
  endtask

  task automatic model_edge(input int k, input logic en, input logic [7:0] r);
    int w;
    m_to[k] = 1'b0;
    if (!m_busy[k]) begin
      w = pick(r, m_last[k]);
      if (en && w >= 0) begin
        m_busy[k] = 1'b1; m_idx[k] = w; m_cnt[k] = 1;
      end
    end else if (!en) begin
      m_busy[k] = 1'b0;
    end else if (!r[m_idx[k]]) begin
      m_last[k] = m_idx[k];
      w = pick(r, m_last[k]);
      if (w >= 0) begin
        m_idx[k] = w; m_cnt[k] = 1;
      end else begin
        m_busy[k] = 1'b0;
      end
    end else if (m_cnt[k] == hm[k]) begin
      m_to[k]   = 1'b1;
      m_last[k] = m_idx[k];
      w = pick(r, m_last[k]);  // holder is scanned last, so it wins only when alone
      m_idx[k]  = w;
      m_cnt[k]  = 1;
    end else begin
      m_cnt[k]++;
    end
  endtask

  // One clock: drive inputs, push expectations, then pop and compare after the edge.
  task automatic step(input logic en, input logic [7:0] r);
    logic [4:0] e;
    if8.arb_en = en; if8.req = r;
    if4.arb_en = en; if4.req = r;
    if1.arb_en = en; if1.req = r;
    for (int k = 0; k < 3; k++) begin
      model_edge(k, en, r);
      exp_q.push_back({m_to[k], m_busy[k], 3'(m_idx[k])});
    end
    @(posedge clk);
    #1;
    n_step++;
    for (int k = 0; k < 3; k++) begin
      e = exp_q.pop_front();
      check($sformatf("%s step %0d", nm[k], n_step), 32'(obs(k)), 32'(e));
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    step_inputs_idle();
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) check($sformatf("%s reset state", nm[k]), 32'(obs(k)), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic step_inputs_idle();
    if8.arb_en = 1'b0; if8.req = 8'h00;
    if4.arb_en = 1'b0; if4.req = 8'h00;
    if1.arb_en = 1'b0; if1.req = 8'h00;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] r;
    logic       en;

    // 1: no requests -> nothing granted.
    apply_reset();
    for (int s = 0; s < 5; s++) begin
      step(1'b1, 8'h00);
      check("idle no req", 32'(obs(0)), 32'd0);
    end

    // 2: req=1010_0100 rotates 2 -> 5 -> 7 -> 2 with 8-cycle grants.
    apply_reset();
    for (int s = 1; s <= 25; s++) begin
      step(1'b1, 8'hA4);
      if (s == 1)  check("rot first 04", 32'(decoded(obs(0))), 32'h04);
      if (s == 8)  check("rot hold 2", 32'(obs(0)), 32'(5'b0_1_010));
      if (s == 9)  check("rot 20 + to", 32'({obs(0)[4], decoded(obs(0))}), 32'h120);
      if (s == 10) check("rot to clears", 32'(obs(0)[4]), 32'd0);
      if (s == 17) check("rot 80 + to", 32'({obs(0)[4], decoded(obs(0))}), 32'h180);
      if (s == 25) check("rot wrap 04", 32'({obs(0)[4], decoded(obs(0))}), 32'h104);
    end

    // 3: lone requester 3, released after three grant cycles.
    apply_reset();
    step(1'b1, 8'h08);
    check("lone grant 3", 32'(obs(0)), 32'(5'b0_1_011));
    step(1'b1, 8'h08);
    step(1'b1, 8'h08);
    step(1'b1, 8'h00);
    check("lone release", 32'(obs(0)[4:3]), 32'd0);

    // 4: release with a waiting requester hands over without a bubble.
    apply_reset();
    step(1'b1, 8'h06);
    check("b2b grant 1", 32'(obs(0)), 32'(5'b0_1_001));
    step(1'b1, 8'h04);
    check("b2b handover 2", 32'(obs(0)), 32'(5'b0_1_010));

    // Release coinciding with the limit: release wins, no timeout.
    apply_reset();
    for (int s = 0; s < 8; s++) step(1'b1, 8'h03);
    step(1'b1, 8'h02);
    check("release beats limit", 32'(obs(0)), 32'(5'b0_1_001));

    // 5: sole requester past the limit (HOLD_MAX 4 and 1).
    apply_reset();
    for (int s = 1; s <= 13; s++) begin
      step(1'b1, 8'h10);
      check($sformatf("sole h4 s%0d", s), 32'(obs(1)),
            32'({(s > 1) && (s % 4 == 1), 1'b1, 3'd4}));
      check($sformatf("sole h1 s%0d", s), 32'(obs(2)), 32'({s > 1, 1'b1, 3'd4}));
    end

    // 6: disable mid-grant, resume rotation, then asynchronous reset.
    apply_reset();
    for (int s = 0; s < 9; s++) step(1'b1, 8'hA4);
    check("pre-disable on 5", 32'(obs(0)), 32'(5'b1_1_101));
    step(1'b0, 8'hA4);
    check("disable drops valid", 32'(obs(0)[3]), 32'd0);
    step(1'b1, 8'hA4);
    check("resume from ptr", 32'(obs(0)), 32'(5'b0_1_101));
    step(1'b1, 8'hA4);
    #3;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) check($sformatf("%s async reset", nm[k]), 32'(obs(k)), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Mixed traffic with sticky requests and occasional disables.
    r = 8'h00;
    for (int s = 0; s < 80; s++) begin
      if ($urandom_range(0, 3) == 0) r = 8'($urandom);
      en = ($urandom_range(0, 9) != 0);
      step(en, r);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
